cache_ctrl: RTL
===============

Name: cache_ctrl

Overview:
- Direct-mapped, write-through controller that drives the 256-entry x 16-bit cache data array.
- Owns the tag/valid store and answers CPU load/store requests, zero-wait on a read hit.
- On a read miss it fetches the word from off-chip memory over a req/ack handshake, then writes it into the data array.
- Sits between the 16-bit MIPS datapath, the cache data array and the DE2 off-chip memory interface.

Parameters:
- ADDR_W, 16, CPU/memory word-address width.
- DATA_W, 16, data word width.
- INDEX_W, 8, cache index width (2^INDEX_W lines, one word per line); tag width = ADDR_W-INDEX_W.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-low reset
- cpu_rd  in  1  load request, held until stall low
- cpu_wr  in  1  store request, held until stall low
- cpu_addr  in  ADDR_W  word address
- cpu_wdata  in  DATA_W  store data
- cpu_rdata  out  DATA_W  load data, valid when cpu_rd & !cpu_stall
- cpu_stall  out  1  freeze pipeline
- cache_addr  out  INDEX_W  data-array index
- cache_wdata  out  DATA_W  data-array write data
- cache_we  out  1  data-array write enable
- cache_rdata  in  DATA_W  data-array asynchronous read data
- mem_req  out  1  off-chip request
- mem_we  out  1  1=write, 0=read; qualified by mem_req
- mem_addr  out  ADDR_W  off-chip word address
- mem_wdata  out  DATA_W  off-chip write data
- mem_rdata  in  DATA_W  off-chip read data, valid with mem_ack
- mem_ack  in  1  one-or-more-cycle completion strobe

Behaviour:
- Reset (rst==0 at posedge): state=IDLE, all valid bits cleared, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, fill register=0. Outputs after reset: cache_we=0, cpu_stall=0 with no request.
- Reset mid-transaction abandons it. mem_req is low after that edge.
- idx = cpu_addr[INDEX_W-1:0]; tag = cpu_addr[ADDR_W-1:INDEX_W]; hit = valid[idx] & (tag_mem[idx]==tag), combinational.
- cache_addr = idx in IDLE, else the latched index. cpu_rdata = cache_rdata, combinational.
- States: IDLE, MISS_RD, FILL, WR_THRU, WR_DONE.
- IDLE:
  - cpu_wr has priority over cpu_rd.
  - cpu_wr: cpu_stall=1; cache_we=hit (write-update on hit, no allocate on miss); cache_wdata=cpu_wdata. Next edge: latch addr/data, mem_req=1, mem_we=1, go WR_THRU.
  - cpu_rd & hit: cpu_stall=0, data returned same cycle, stay IDLE.
  - cpu_rd & !hit: cpu_stall=1. Next edge: latch addr, mem_req=1, mem_we=0, go MISS_RD.
- MISS_RD:
  - cpu_stall=1; hold mem_req/mem_addr.
  - At the edge where mem_ack==1: capture mem_rdata into fill register, mem_req=0, go FILL.
- FILL:
  - cpu_stall=1, cache_we=1, cache_wdata=fill register.
  - At the edge: tag_mem[idx]<=tag, valid[idx]<=1, go IDLE. The held cpu_rd then hits.
  - Miss penalty = 2 + ack-wait cycles + the hit cycle.
- WR_THRU:
  - cpu_stall=1; hold mem_req/mem_we/mem_addr/mem_wdata.
  - On mem_ack: mem_req=0, mem_we=0, go WR_DONE.
- WR_DONE:
  - cpu_stall=0 for exactly one cycle so the store retires; go IDLE. No cache or memory write.
- mem_ack is ignored in IDLE, FILL and WR_DONE.
- mem_req never reasserts in the cycle immediately after an ack.
- cache_we is never asserted outside IDLE-write-hit and FILL.
- A read miss whose line holds another tag overwrites it; no writeback is needed under write-through.
- Index 0 and index 255 behave identically; there is no wrap logic beyond address truncation.

Test Plan:
- Reset, then cpu_rd addr 0x1234 with mem_ack after 3 cycles, mem_rdata=0xBEEF:
  - mem_req=1, mem_addr=0x1234 for 3 cycles.
  - FILL writes 0xBEEF at index 0x34.
  - Next cycle stall=0, cpu_rdata=0xBEEF; 6 cycles total.
- Repeat read 0x1234 → stall=0 in the first cycle, mem_req stays 0.
- Read 0x5634 (same index, new tag) → miss and refill. Then read 0x1234 → miss again, confirming eviction.
- cpu_wr 0x1234 data 0x0F0F while line valid:
  - cache_we=1 in IDLE; mem_req=1, mem_we=1, mem_wdata=0x0F0F until ack; one stall-free WR_DONE cycle.
  - Subsequent read hits with 0x0F0F.
- cpu_wr 0x00FF on a miss → cache_we stays 0. A later read of 0x00FF misses.
- rst=0 during MISS_RD → mem_req=0 next cycle, state IDLE; previously valid 0x1234 now misses. Also check cpu_rd&cpu_wr together → write path is taken.

Source files
------------

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through cache controller with off-chip fill
module cache_ctrl #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int INDEX_W = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_rd,
    input  logic               cpu_wr,
    input  logic [ADDR_W-1:0]  cpu_addr,
    input  logic [DATA_W-1:0]  cpu_wdata,
    output logic [DATA_W-1:0]  cpu_rdata,
    output logic               cpu_stall,
    output logic [INDEX_W-1:0] cache_addr,
    output logic [DATA_W-1:0]  cache_wdata,
    output logic               cache_we,
    input  logic [DATA_W-1:0]  cache_rdata,
    output logic               mem_req,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    input  logic [DATA_W-1:0]  mem_rdata,
    input  logic               mem_ack
);

    localparam int TAG_W = ADDR_W - INDEX_W;
    localparam int LINES = 1 << INDEX_W;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        MISS_RD = 3'd1,
        FILL    = 3'd2,
        WR_THRU = 3'd3,
        WR_DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [LINES-1:0]    valid_q;
    logic [TAG_W-1:0]    tag_q [LINES];
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0]   fill_q, fill_d;
    logic                fill_commit;

    logic [INDEX_W-1:0]  idx;
    logic [TAG_W-1:0]    tag;
    logic [INDEX_W-1:0]  lat_idx;
    logic [TAG_W-1:0]    lat_tag;
    logic                hit;

    // Lookup is purely combinational so a read hit completes with zero wait.
    // The latched miss address doubles as the off-chip address register.
    assign idx     = cpu_addr[INDEX_W-1:0];
    assign tag     = cpu_addr[ADDR_W-1:INDEX_W];
    assign lat_idx = mem_addr_q[INDEX_W-1:0];
    assign lat_tag = mem_addr_q[ADDR_W-1:INDEX_W];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);

    assign cpu_rdata = cache_rdata;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    // Next-state and output decode; writes take priority over reads in IDLE.
    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        fill_d      = fill_q;
        fill_commit = 1'b0;
        cpu_stall   = 1'b0;
        cache_we    = 1'b0;
        cache_wdata = cpu_wdata;
        cache_addr  = lat_idx;

        case (state_q)
            IDLE: begin
                cache_addr = idx;
                if (cpu_wr) begin
                    // Update the line only if it already holds this address;
                    // a store miss does not allocate.
                    cpu_stall   = 1'b1;
                    cache_we    = hit;
                    mem_req_d   = 1'b1;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = cpu_addr;
                    mem_wdata_d = cpu_wdata;
                    state_d     = WR_THRU;
                end else if (cpu_rd && !hit) begin
                    cpu_stall  = 1'b1;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = cpu_addr;
                    state_d    = MISS_RD;
                end
            end
            MISS_RD: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    fill_d    = mem_rdata;
                    mem_req_d = 1'b0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                // Any previous tag in this line is simply overwritten; memory
                // is always up to date so nothing needs writing back.
                cpu_stall   = 1'b1;
                cache_we    = 1'b1;
                cache_wdata = fill_q;
                fill_commit = 1'b1;
                state_d     = IDLE;
            end
            WR_THRU: begin
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    mem_we_d  = 1'b0;
                    state_d   = WR_DONE;
                end
            end
            WR_DONE: begin
                // One stall-free cycle lets the store retire before IDLE
                // can see the (now dropped) cpu_wr again.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, memory-interface and valid registers; reset abandons any transaction.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            fill_q      <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            fill_q      <= fill_d;
            if (fill_commit) begin
                valid_q[lat_idx] <= 1'b1;
            end
        end
    end

    // Tag store needs no reset: a tag is only meaningful under its valid bit.
    always_ff @(posedge clk) begin
        if (rst && fill_commit) begin
            tag_q[lat_idx] <= lat_tag;
        end
    end

endmodule
